exibidor_status: RTL and testbench

- Consumer end of the pet state controller's output interface: takes `estado[2:0]` and the three 8-bit levels (`fome`, `sono`, `felicidade`) and drives the board's 4-digit 7-segment display, the state LEDs and the alert LED.
- Cycles one level per page on the display: a page letter followed by a 3-digit decimal value.
- Uses a sequential double-dabble BCD converter and a multiplexed digit scanner.

---
 rtl/exibidor_status.sv | 261 ++++++++++++++++++++++++++
 tb/tb_exibidor_status.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/exibidor_status.sv
// Status display for the pet controller: pages through the three levels on a
// 4-digit 7-segment display, drives the one-hot state LEDs and the alert LED.
module exibidor_status #(
  parameter int SCAN_DIV  = 2,
  parameter int PAGE_DIV  = 100,
  parameter int BLINK_DIV = 50,
  parameter int LIMIAR    = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] estado,
  input  logic [7:0] fome,
  input  logic [7:0] sono,
  input  logic [7:0] felicidade,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic [4:0] leds,
  output logic       alerta
);

  localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int PW = (PAGE_DIV  > 1) ? $clog2(PAGE_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_e;

  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]    digit_idx_q, digit_idx_d;
  logic [PW-1:0] page_cnt_q, page_cnt_d;
  logic [1:0]    page_q, page_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;
  conv_state_e   state_q, state_d;
  logic [2:0]    shift_cnt_q, shift_cnt_d;
  logic [19:0]   dd_q, dd_d;
  logic [1:0]    tag_q, tag_d;
  logic [11:0]   bcd_q, bcd_d;
  logic          bcd_valid_q, bcd_valid_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic [4:0]    leds_q, leds_d;
  logic          alerta_q, alerta_d;

  logic          scan_wrap_s, page_wrap_s, blink_wrap_s;
  logic [7:0]    level_s;
  logic          low_s, morto_s;
  logic [19:0]   dd_adj_s;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0:    dec7 = 7'b1000000;
      4'd1:    dec7 = 7'b1111001;
      4'd2:    dec7 = 7'b0100100;
      4'd3:    dec7 = 7'b0110000;
      4'd4:    dec7 = 7'b0011001;
      4'd5:    dec7 = 7'b0010010;
      4'd6:    dec7 = 7'b0000010;
      4'd7:    dec7 = 7'b1111000;
      4'd8:    dec7 = 7'b0000000;
      4'd9:    dec7 = 7'b0010000;
      default: dec7 = 7'b1111111;
    endcase
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    if (n >= 4'd5) begin
      add3 = n + 4'd3;
    end else begin
      add3 = n;
    end
  endfunction

  // Double-dabble step: correct each BCD nibble before the left shift.
  function automatic logic [19:0] dd_adjust(input logic [19:0] v);
    dd_adjust = {add3(v[19:16]), add3(v[15:12]), add3(v[11:8]), v[7:0]};
  endfunction

  assign seg    = seg_q;
  assign an     = an_q;
  assign leds   = leds_q;
  assign alerta = alerta_q;

  // Next-state logic for dividers, converter FSM and registered outputs.
  always_comb begin
    scan_cnt_d  = scan_cnt_q;
    digit_idx_d = digit_idx_q;
    page_cnt_d  = page_cnt_q;
    page_d      = page_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q;
    dd_d        = dd_q;
    tag_d       = tag_q;
    bcd_d       = bcd_q;
    bcd_valid_d = bcd_valid_q;
    seg_d       = SEG_BLANK;
    an_d        = 4'b1111;
    leds_d      = 5'b00000;
    alerta_d    = 1'b0;
    level_s     = fome;
    dd_adj_s    = dd_adjust(dd_q);

    scan_wrap_s  = (scan_cnt_q  == SW'(SCAN_DIV - 1));
    page_wrap_s  = (page_cnt_q  == PW'(PAGE_DIV - 1));
    blink_wrap_s = (blink_cnt_q == BW'(BLINK_DIV - 1));

    if (scan_wrap_s) begin
      scan_cnt_d  = '0;
      digit_idx_d = digit_idx_q + 2'd1;
    end else begin
      scan_cnt_d  = scan_cnt_q + SW'(1);
      digit_idx_d = digit_idx_q;
    end

    if (page_wrap_s) begin
      page_cnt_d = '0;
      page_d     = (page_q == 2'd2) ? 2'd0 : page_q + 2'd1;
    end else begin
      page_cnt_d = page_cnt_q + PW'(1);
      page_d     = page_q;
    end

    if (blink_wrap_s) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BW'(1);
      blink_d     = blink_q;
    end

    case (page_q)
      2'd0:    level_s = fome;
      2'd1:    level_s = sono;
      2'd2:    level_s = felicidade;
      default: level_s = fome;
    endcase

    case (state_q)
      ST_LOAD: begin
        dd_d        = {12'd0, level_s};
        tag_d       = page_q;
        shift_cnt_d = 3'd0;
        state_d     = ST_SHIFT;
      end
      ST_SHIFT: begin
        dd_d        = {dd_adj_s[18:0], 1'b0};
        shift_cnt_d = shift_cnt_q + 3'd1;
        if (shift_cnt_q == 3'd7) begin
          state_d = ST_COMMIT;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_COMMIT: begin
        // A page wrap on this edge wins: the result belongs to the old page.
        if ((tag_q == page_q) && !page_wrap_s) begin
          bcd_d       = dd_q[19:8];
          bcd_valid_d = 1'b1;
        end else begin
          bcd_d       = bcd_q;
          bcd_valid_d = bcd_valid_q;
        end
        state_d = ST_LOAD;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase

    if (page_wrap_s) begin
      bcd_valid_d = 1'b0;
    end else begin
      bcd_valid_d = bcd_valid_d;
    end

    morto_s = (estado == 3'd4);
    low_s   = (fome < 8'(LIMIAR)) || (sono < 8'(LIMIAR)) || (felicidade < 8'(LIMIAR));

    case (digit_idx_q)
      2'd0: seg_d = bcd_valid_q ? dec7(bcd_q[3:0]) : SEG_BLANK;
      2'd1: seg_d = (!bcd_valid_q || (bcd_q[11:4] == 8'd0)) ? SEG_BLANK : dec7(bcd_q[7:4]);
      2'd2: seg_d = (!bcd_valid_q || (bcd_q[11:8] == 4'd0)) ? SEG_BLANK : dec7(bcd_q[11:8]);
      2'd3: begin
        case (page_q)
          2'd0:    seg_d = 7'b0001110;
          2'd1:    seg_d = 7'b0010010;
          2'd2:    seg_d = 7'b0001001;
          default: seg_d = SEG_BLANK;
        endcase
      end
      default: seg_d = SEG_BLANK;
    endcase

    if (morto_s) begin
      seg_d    = SEG_DASH;
      alerta_d = 1'b1;
    end else begin
      seg_d    = seg_d;
      alerta_d = blink_q & low_s;
    end

    an_d = ~(4'b0001 << digit_idx_q);

    case (estado)
      3'd0:    leds_d = 5'b00001;
      3'd1:    leds_d = 5'b00010;
      3'd2:    leds_d = 5'b00100;
      3'd3:    leds_d = 5'b01000;
      3'd4:    leds_d = 5'b10000;
      default: leds_d = 5'b00000;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt_q  <= '0;
      digit_idx_q <= 2'd0;
      page_cnt_q  <= '0;
      page_q      <= 2'd0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      state_q     <= ST_LOAD;
      shift_cnt_q <= 3'd0;
      dd_q        <= 20'd0;
      tag_q       <= 2'd0;
      bcd_q       <= 12'd0;
      bcd_valid_q <= 1'b0;
      seg_q       <= SEG_BLANK;
      an_q        <= 4'b1111;
      leds_q      <= 5'b00000;
      alerta_q    <= 1'b0;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      digit_idx_q <= digit_idx_d;
      page_cnt_q  <= page_cnt_d;
      page_q      <= page_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      state_q     <= state_d;
      shift_cnt_q <= shift_cnt_d;
      dd_q        <= dd_d;
      tag_q       <= tag_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      leds_q      <= leds_d;
      alerta_q    <= alerta_d;
    end
  end

endmodule

// File: tb/tb_exibidor_status.sv
// Scoreboard bench for exibidor_status: expected outputs per clock edge are
// derived from elapsed-time arithmetic and a history of the applied levels.
module tb_exibidor_status;

  localparam int SCAN  = 2;
  localparam int PAGE  = 100;
  localparam int BLINK = 50;
  localparam int LIM   = 20;
  localparam int HMAX  = 4096;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] estado;
  logic [7:0] fome, sono, felicidade;
  logic [6:0] seg;
  logic [3:0] an;
  logic [4:0] leds;
  logic       alerta;

  always #5 clk = ~clk;

  exibidor_status #(
    .SCAN_DIV(SCAN), .PAGE_DIV(PAGE), .BLINK_DIV(BLINK), .LIMIAR(LIM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .estado(estado), .fome(fome), .sono(sono),
    .felicidade(felicidade), .seg(seg), .an(an), .leds(leds), .alerta(alerta)
  );

  typedef struct {
    logic [6:0] seg;
    logic [3:0] an;
    logic [4:0] leds;
    logic       alerta;
    int         k;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int k = 0;
  int hf[HMAX];
  int hs[HMAX];
  int hh[HMAX];
  int he[HMAX];

  function automatic logic [6:0] dec7(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected outputs just after edge kk (kk counts edges since reset release).
  function automatic exp_t model(input int kk);
    exp_t r;
    int idx, pg, c, w, v, h, t, u, e;
    bit valid, low;
    idx = (kk / SCAN) % 4;
    pg  = (kk / PAGE) % 3;
    e   = he[kk];
    r.k  = kk;
    r.an = ~(4'b0001 << idx);
    r.leds = (e <= 4) ? (5'b00001 << e) : 5'b00000;
    low = (hf[kk] < LIM) || (hs[kk] < LIM) || (hh[kk] < LIM);
    r.alerta = (e == 4) ? 1'b1 : ((((kk / BLINK) % 2) == 1) && low);
    // Conversions start every 10 edges; the last finished one counts only if
    // it completed after the most recent page change and not on it.
    valid = 1'b0;
    v = 0;
    if (kk >= 10) begin
      c = ((kk - 10) / 10) * 10 + 9;
      w = (kk >= PAGE) ? ((kk - PAGE) / PAGE) * PAGE + PAGE - 1 : -1;
      valid = (c % PAGE != PAGE - 1) && (c > w);
      v = (pg == 0) ? hf[c - 9] : (pg == 1) ? hs[c - 9] : hh[c - 9];
    end
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    if (e == 4) r.seg = 7'b0111111;
    else if (idx == 3) r.seg = (pg == 0) ? 7'b0001110 : (pg == 1) ? 7'b0010010 : 7'b0001001;
    else if (!valid) r.seg = 7'b1111111;
    else if (idx == 2) r.seg = (h == 0) ? 7'b1111111 : dec7(h);
    else if (idx == 1) r.seg = (h == 0 && t == 0) ? 7'b1111111 : dec7(t);
    else r.seg = dec7(u);
    return r;
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] expv, input int kk);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at k=%0d t=%0t: got %b expected %b", nm, kk, $time, act, expv);
    end
  endtask

  // Monitor: every edge presents a display frame; compare it with the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("seg",    {1'b0, seg},    {1'b0, e.seg},    e.k);
      check("an",     {4'b0, an},     {4'b0, e.an},     e.k);
      check("leds",   {3'b0, leds},   {3'b0, e.leds},   e.k);
      check("alerta", {7'b0, alerta}, {7'b0, e.alerta}, e.k);
    end
  end

  task automatic cyc();
    exp_t e;
    if (!rst_n) begin
      e.seg = 7'b1111111; e.an = 4'b1111; e.leds = 5'b00000; e.alerta = 1'b0; e.k = -1;
      k = 0;
    end else begin
      hf[k] = fome; hs[k] = sono; hh[k] = felicidade; he[k] = estado;
      e = model(k);
      if (k < HMAX - 1) k++;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pick_level();
    case ($urandom_range(0, 2))
      0:       return 8'($urandom_range(0, 255));
      1:       return 8'($urandom_range(0, 30));
      default: return 8'($urandom_range(18, 21));
    endcase
  endfunction

  task automatic random_bursts(input int n);
    for (int i = 0; i < n; i++) begin
      estado     = ($urandom_range(0, 9) < 7) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      fome       = pick_level();
      sono       = pick_level();
      felicidade = pick_level();
      repeat ($urandom_range(5, 40)) cyc();
    end
  endtask

  initial begin
    rst_n = 1'b0; estado = 3'd0; fome = 8'd100; sono = 8'd100; felicidade = 8'd100;
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (5) cyc();
    fome = 8'd255;
    repeat (35) cyc();
    fome = 8'd7;
    repeat (40) cyc();
    sono = 8'd0; felicidade = 8'd42;
    repeat (220) cyc();
    estado = 3'd3; fome = 8'd100; sono = 8'd100; felicidade = 8'd19;
    repeat (150) cyc();
    felicidade = 8'd20;
    repeat (100) cyc();
    estado = 3'd4;
    repeat (60) cyc();
    estado = 3'd6;
    repeat (20) cyc();
    random_bursts(25);
    // Single-cycle reset landing in the middle of a conversion.
    estado = 3'd0; fome = 8'd255;
    while ((k % 10) != 3) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    repeat (150) cyc();
    random_bursts(10);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
